// File: rtl/dvp_capture_pkg.sv
// Shared types and layout constants for the DVP capture block.
`timescale 1ns / 1ps
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitVs    = 2'd1,
    StWaitFrame = 2'd2,
    StActive    = 2'd3
  } state_e;

  localparam int unsigned FrameCntW = 16;

  // FIFO entry layout is {sof, eol, data[d-1:0]}
  function automatic int unsigned sof_bit(int unsigned d);
    return d + 1;
  endfunction

  function automatic int unsigned eol_bit(int unsigned d);
    return d;
  endfunction

endpackage

// File: rtl/dvp_sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is visible on rd_data whenever !empty.
`timescale 1ns / 1ps
module dvp_sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   cnt_q;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == (AddrW + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is still accepted when a read frees a slot this cycle
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr_q];

  // Storage array, no reset needed
  always_ff @(posedge pclk) begin
    if (do_wr) mem[wptr_q] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AddrW + 1)'(do_wr) - (AddrW + 1)'(do_rd);
    end
  end

endmodule

// File: rtl/dvp_capture.sv
// DVP UYVY receiver: frame sync, Y extraction, geometry checks and pixel FIFO.
`timescale 1ns / 1ps
module dvp_capture
  import dvp_capture_pkg::*;
#(
  parameter int unsigned D          = 8,
  parameter int unsigned WDT        = 64,
  parameter int unsigned HGT        = 48,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [D-1:0]         din,
  output logic [D-1:0]         m_tdata,
  output logic                 m_tuser,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  input  logic                 err_clr,
  output logic                 line_err,
  output logic                 frame_err,
  output logic                 ovf,
  output logic [FrameCntW-1:0] frame_cnt,
  output logic                 busy
);

  localparam int unsigned XW     = $clog2(WDT + 2);
  localparam int unsigned YW     = $clog2(HGT + 2);
  localparam int unsigned EW     = D + 2;
  localparam int unsigned SofBit = sof_bit(D);
  localparam int unsigned EolBit = eol_bit(D);
  localparam logic [XW-1:0] XLast = XW'(WDT - 1);
  localparam logic [XW-1:0] XEnd  = XW'(WDT);
  localparam logic [XW-1:0] XSat  = XW'(WDT + 1);
  localparam logic [YW-1:0] YEnd  = YW'(HGT);
  localparam logic [YW-1:0] YSat  = YW'(HGT + 1);

  state_e         state_q, state_d;
  logic           vs_r, hr_r, vs_r2, hr_r2, bph;
  logic [D-1:0]   d_r;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           vs_rise, vs_fall, hr_fall, active, y_byte, push, pop;
  logic           clr_xy, frame_end, line_set, frame_set, ovf_set;
  logic           fifo_full, fifo_empty;
  logic [EW-1:0]  wr_entry, rd_entry, head;

  // Input register stage plus a second copy for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r  <= 1'b0;
      hr_r  <= 1'b0;
      d_r   <= '0;
      vs_r2 <= 1'b0;
      hr_r2 <= 1'b0;
    end else begin
      vs_r  <= vsync;
      hr_r  <= href;
      d_r   <= din;
      vs_r2 <= vs_r;
      hr_r2 <= hr_r;
    end
  end

  assign vs_rise = vs_r && !vs_r2;
  assign vs_fall = !vs_r && vs_r2;
  assign hr_fall = !hr_r && hr_r2;
  assign active  = (state_q == StActive);
  assign y_byte  = hr_r && bph;
  assign push    = active && y_byte && (x_q < XEnd);
  assign pop     = m_tvalid && m_tready;

  // Byte phase: 0 = chroma, 1 = luma; realigned at every href gap
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)    bph <= 1'b0;
    else if (hr_r) bph <= !bph;
    else           bph <= 1'b0;
  end

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; a started frame always runs to its closing vsync
  always_comb begin
    state_d   = state_q;
    clr_xy    = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle:      if (en) state_d = StWaitVs;
      StWaitVs:    if (vs_r) state_d = StWaitFrame;
      StWaitFrame: begin
        if (vs_fall) begin
          clr_xy  = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = en ? StWaitFrame : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel/line position; both saturate so overlong lines and frames stay detectable
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_xy) begin
      x_q <= '0;
      y_q <= '0;
    end else if (active) begin
      if (hr_fall) begin
        x_q <= '0;
        if (y_q != YSat) y_q <= y_q + 1'b1;
      end else if (y_byte && (x_q != XSat)) begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign line_set  = active && hr_fall && ((x_q != XEnd) || bph);
  assign frame_set = frame_end && (y_q != YEnd);
  assign ovf_set   = push && fifo_full && !pop;

  // Sticky errors (set beats clear) and completed-frame counter
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      line_err  <= line_set  || (line_err  && !err_clr);
      frame_err <= frame_set || (frame_err && !err_clr);
      ovf       <= ovf_set   || (ovf       && !err_clr);
      if (frame_end && (y_q == YEnd)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign wr_entry = {(x_q == '0) && (y_q == '0), (x_q == XLast), d_r};

  dvp_sync_fifo #(
    .Width(EW),
    .Depth(FIFO_DEPTH),
    .AddrW(FIFO_AW)
  ) u_fifo (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data(wr_entry),
    .rd_en  (pop),
    .rd_data(rd_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Mask the uninitialised storage so the stream reads as zero when empty
  assign head     = fifo_empty ? '0 : rd_entry;
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head[D-1:0];
  assign m_tlast  = head[EolBit];
  assign m_tuser  = head[SofBit];
  assign busy     = active;

endmodule

// File: tb/tb_dvp_capture.sv
// Self-checking bench: camera model drives UYVY frames, expected Y stream built from the image.
`timescale 1ns / 1ps
module tb_dvp_capture;
  localparam int unsigned D   = 8;
  localparam int unsigned WDT = 64;
  localparam int unsigned HGT = 48;

  logic         pclk = 1'b0, rst_n = 1'b0, en = 1'b0, vsync = 1'b0, href = 1'b0;
  logic         m_tready = 1'b1, err_clr = 1'b0;
  logic [D-1:0] din = '0;
  logic [D-1:0] m_tdata;
  logic         m_tuser, m_tlast, m_tvalid, line_err, frame_err, ovf, busy;
  logic [15:0]  frame_cnt;

  int           vectors = 0, miscompares = 0, exp_cnt = 0;
  logic [D+1:0] exp_q[$];
  logic [D+1:0] rcv[$];

  always #5 pclk = ~pclk;

  dvp_capture #(.D(D), .WDT(WDT), .HGT(HGT), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .vsync(vsync), .href(href), .din(din),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .err_clr(err_clr), .line_err(line_err), .frame_err(frame_err),
    .ovf(ovf), .frame_cnt(frame_cnt), .busy(busy)
  );

  // Collector: a beat transfers at the next rising edge when valid&&ready here
  always @(negedge pclk) if (m_tvalid && m_tready) rcv.push_back({m_tuser, m_tlast, m_tdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_vsync();
    href = 1'b0;
    vsync = 1'b1;
    repeat (4) cyc();
    vsync = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    cyc();
  endtask

  // Lines of the frame, then the closing vsync. Expected pixels follow the spec rules directly.
  task automatic send_frame(input int nlines, input bit capture, input int short_y,
                            input int en_y, input int stall_y, input int rst_y);
    int           len;
    logic [D-1:0] v;
    logic [D+2:0] held;
    for (int y = 0; y < nlines; y++) begin
      len = (y == short_y) ? WDT - 1 : WDT;
      if (y == en_y) en = 1'b1;
      for (int b = 0; b < 2 * len; b++) begin
        v = D'($urandom);
        href = 1'b1;
        din = v;
        if (y == stall_y && b == 20) m_tready = 1'b0;
        if (y == stall_y && b == 60) m_tready = 1'b1;
        if (y == stall_y && b == 30) begin
          held = {m_tvalid, m_tuser, m_tlast, m_tdata};
          vectors++;
          if (m_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_valid: got %b want 1", m_tvalid);
          end
        end
        if (y == stall_y && b == 58) begin
          vectors++;
          if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== held) begin
            miscompares++;
            $display("FAIL stall_hold: got %h want %h", {m_tvalid, m_tuser, m_tlast, m_tdata},
                     held);
          end
        end
        if (y == rst_y && b == 30) begin
          rst_n = 1'b0;
          #1;
          vectors++;
          if ({m_tvalid, m_tdata, m_tuser, m_tlast, line_err, frame_err, ovf, busy, frame_cnt}
              !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b busy=%b cnt=%0d errs=%b%b%b want all 0",
                     m_tvalid, busy, frame_cnt, line_err, frame_err, ovf);
          end
          rcv.delete();
        end
        if (y == rst_y && b == 34) rst_n = 1'b1;
        if (capture && (b % 2 == 1))
          exp_q.push_back({(b == 1 && y == 0), (b / 2 == WDT - 1), v});
        cyc();
      end
      href = 1'b0;
      din = '0;
      repeat (8) cyc();
    end
    send_vsync();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    vectors++;
    if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== '0) begin
      miscompares++;
      $display("FAIL reset_stream: got %b want 0", {m_tvalid, m_tdata, m_tuser, m_tlast});
    end
    vectors++;
    if ({line_err, frame_err, ovf} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_errs: got %b want 000", {line_err, frame_err, ovf});
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
    rst_n = 1'b1;
    repeat (2) cyc();
    vectors++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, m_tvalid);
    end
  endtask

  task automatic test_en_midframe();
    en = 1'b0;
    exp_q.delete();
    rcv.delete();
    send_vsync();
    send_frame(24, 1'b0, -1, 20, -1, -1);
    vectors++;
    if (rcv.size() != 0 || frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL en_mid_skip: got %0d pixels cnt %0d want 0 pixels cnt %0d",
               rcv.size(), frame_cnt, exp_cnt);
    end
    send_frame(HGT, 1'b1, -1, -1, -1, -1);
    exp_cnt++;
    vectors++;
    if (rcv.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL en_mid_len: got %0d want %0d", rcv.size(), exp_q.size());
    end
    for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rcv[i] !== exp_q[i]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL en_mid_px%0d: got %h want %h", i, rcv[i], exp_q[i]);
      end
    end
    vectors++;
    if (rcv.size() == 0 || rcv[0][D+1] !== 1'b1 || frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL en_mid_first: got n=%0d cnt=%0d want tuser on first, cnt %0d",
               rcv.size(), frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_stream();
    exp_q.delete();
    rcv.delete();
    send_frame(HGT, 1'b1, -1, -1, -1, -1);
    exp_cnt++;
    vectors++;
    if (rcv.size() != WDT * HGT) begin
      miscompares++;
      $display("FAIL stream_len: got %0d want %0d", rcv.size(), WDT * HGT);
    end
    for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rcv[i] !== exp_q[i]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL stream_px%0d: got %h want %h", i, rcv[i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(exp_cnt) || {line_err, frame_err, ovf} !== 3'b000 || busy !== 1'b1)
    begin
      miscompares++;
      $display("FAIL stream_status: got cnt=%0d errs=%b busy=%b want cnt=%0d errs=000 busy=1",
               frame_cnt, {line_err, frame_err, ovf}, busy, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int j;
    bit ok;
    exp_q.delete();
    rcv.delete();
    send_frame(HGT, 1'b1, -1, -1, 5, -1);
    exp_cnt++;
    vectors++;
    if (ovf !== 1'b1 || line_err !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL bp_flags: got ovf=%b line_err=%b cnt=%0d want 1 0 %0d",
               ovf, line_err, frame_cnt, exp_cnt);
    end
    vectors++;
    if (rcv.size() >= exp_q.size() || rcv.size() < exp_q.size() - 40) begin
      miscompares++;
      $display("FAIL bp_len: got %0d want a few less than %0d", rcv.size(), exp_q.size());
    end
    // Received stream must be an in-order subsequence of the image
    j = 0;
    ok = 1'b1;
    foreach (rcv[i]) begin
      while (j < exp_q.size() && exp_q[j] !== rcv[i]) j++;
      if (j >= exp_q.size()) ok = 1'b0;
      j++;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_order: got stream not a subsequence, want ordered survivors");
    end
    vectors++;
    if (rcv.size() == 0 || rcv[rcv.size()-1] !== exp_q[exp_q.size()-1]) begin
      miscompares++;
      $display("FAIL bp_tail: got last %h want %h", (rcv.size() == 0) ? '0 : rcv[rcv.size()-1],
               exp_q[exp_q.size()-1]);
    end
    pulse_clr();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_clr: got ovf=%b want 0", ovf);
    end
  endtask

  task automatic test_short_line();
    exp_q.delete();
    rcv.delete();
    send_frame(HGT, 1'b1, 3, -1, -1, -1);
    exp_cnt++;
    vectors++;
    if (rcv.size() != exp_q.size() || rcv.size() != WDT * HGT - 1) begin
      miscompares++;
      $display("FAIL short_line_len: got %0d want %0d", rcv.size(), WDT * HGT - 1);
    end
    for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rcv[i] !== exp_q[i]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL short_line_px%0d: got %h want %h", i, rcv[i], exp_q[i]);
      end
    end
    vectors++;
    if (line_err !== 1'b1 || frame_err !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL short_line_flags: got line_err=%b frame_err=%b cnt=%0d want 1 0 %0d",
               line_err, frame_err, frame_cnt, exp_cnt);
    end
    pulse_clr();
    vectors++;
    if (line_err !== 1'b0) begin
      miscompares++;
      $display("FAIL short_line_clr: got %b want 0", line_err);
    end
  endtask

  task automatic test_short_frame();
    exp_q.delete();
    rcv.delete();
    send_frame(HGT - 1, 1'b1, -1, -1, -1, -1);
    vectors++;
    if (frame_err !== 1'b1 || line_err !== 1'b0 || frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL short_frame_flags: got frame_err=%b line_err=%b cnt=%0d want 1 0 %0d",
               frame_err, line_err, frame_cnt, exp_cnt);
    end
    send_frame(HGT, 1'b1, -1, -1, -1, -1);
    exp_cnt++;
    vectors++;
    if (rcv.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL short_frame_len: got %0d want %0d", rcv.size(), exp_q.size());
    end
    for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rcv[i] !== exp_q[i]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL short_frame_px%0d: got %h want %h", i, rcv[i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL short_frame_recover: got cnt=%0d want %0d", frame_cnt, exp_cnt);
    end
    pulse_clr();
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL short_frame_clr: got %b want 0", frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    exp_q.delete();
    rcv.delete();
    send_frame(12, 1'b0, -1, -1, -1, 10);
    exp_cnt = 0;
    vectors++;
    if (rcv.size() != 0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_frame_skip: got %0d pixels cnt=%0d want 0 0", rcv.size(), frame_cnt);
    end
    send_frame(HGT, 1'b1, -1, -1, -1, -1);
    exp_cnt++;
    vectors++;
    if (rcv.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rst_resync_len: got %0d want %0d", rcv.size(), exp_q.size());
    end
    for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (rcv[i] !== exp_q[i]) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL rst_resync_px%0d: got %h want %h", i, rcv[i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(exp_cnt) || rcv.size() == 0 || rcv[0][D+1] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_resync_first: got cnt=%0d n=%0d want cnt=%0d, tuser on first",
               frame_cnt, rcv.size(), exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_en_midframe();
    test_stream();
    test_backpressure();
    test_short_line();
    test_short_frame();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
